// File: rtl/sha256_digest_checker.sv
// SHA-256 digest checker: reassembles the serial digest stream, counts
// leading zero bits 32 bits per cycle and grades it against a difficulty.
module sha256_digest_checker #(
    parameter int WORD_BITS   = 10,
    parameter int NUM_WORDS   = 26,
    parameter int DIGEST_BITS = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [WORD_BITS-1:0]   hash_in,
    input  logic [8:0]             difficulty,
    output logic [DIGEST_BITS-1:0] digest_out,
    output logic [8:0]             leading_zeros,
    output logic                   meets_target,
    output logic                   result_valid,
    output logic                   frame_error,
    output logic                   busy
);

    localparam int FRAME_BITS = WORD_BITS * NUM_WORDS;
    localparam int PAD_BITS   = FRAME_BITS - DIGEST_BITS;
    localparam int SEGS       = DIGEST_BITS / 32;
    localparam int CNT_W      = $clog2(NUM_WORDS + 1);
    localparam int SEG_W      = $clog2(SEGS);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        REPORT,
        DRAIN
    } state_t;

    state_t                  state;
    logic [FRAME_BITS-1:0]   frame_q;
    logic [CNT_W-1:0]        cnt;
    logic [SEG_W-1:0]        seg_idx;
    logic                    zero_run;
    logic [8:0]              acc;
    logic [8:0]              diff_q;
    logic [31:0]             seg;
    logic [5:0]              seg_clz;
    logic [FRAME_BITS-1:0]   frame_shift;
    logic [FRAME_BITS-1:0]   frame_rot;

    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 6'd1;
            end
        end
        return n;
    endfunction

    // The digest part of the frame is rotated by one segment per CHECK
    // cycle, so after all segments it is back in place for digest_out.
    always_comb begin
        seg         = frame_q[FRAME_BITS-1 -: 32];
        seg_clz     = clz32(seg);
        frame_shift = {frame_q[FRAME_BITS-WORD_BITS-1:0], hash_in};
        frame_rot   = {frame_q[FRAME_BITS-33:PAD_BITS],
                       frame_q[FRAME_BITS-1 -: 32],
                       frame_q[PAD_BITS-1:0]};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            frame_q       <= '0;
            cnt           <= '0;
            seg_idx       <= '0;
            zero_run      <= 1'b0;
            acc           <= '0;
            diff_q        <= '0;
            digest_out    <= '0;
            leading_zeros <= '0;
            meets_target  <= 1'b0;
            result_valid  <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            frame_error  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_in) begin
                        frame_q <= frame_shift;
                        cnt     <= CNT_W'(1);
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (valid_in) begin
                        frame_q <= frame_shift;
                        if (cnt == CNT_W'(NUM_WORDS - 1)) begin
                            cnt      <= '0;
                            seg_idx  <= '0;
                            zero_run <= 1'b1;
                            acc      <= '0;
                            state    <= CHECK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        frame_error <= 1'b1;
                        cnt         <= '0;
                        state       <= IDLE;
                    end
                end
                CHECK: begin
                    frame_q <= frame_rot;
                    if (seg_idx == '0) diff_q <= difficulty;
                    if (zero_run) begin
                        acc <= acc + {3'b000, seg_clz};
                        if (seg != 32'd0) zero_run <= 1'b0;
                    end
                    seg_idx <= seg_idx + 1'b1;
                    if (seg_idx == SEG_W'(SEGS - 1)) state <= REPORT;
                end
                REPORT: begin
                    digest_out    <= frame_q[FRAME_BITS-1:PAD_BITS];
                    leading_zeros <= acc;
                    meets_target  <= (acc >= diff_q);
                    result_valid  <= 1'b1;
                    state         <= valid_in ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (!valid_in) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
